// File: rtl/io_bus_master_pkg.sv
// io_bus_master shared definitions.
// Operation codes and FSM state encodings.
package io_bus_master_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_SETBIT = 2'd2,
    OP_CLRBIT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/io_bus_master.sv
// I/O register bus master: read, write and
// read-modify-write bit set/clear over a tristate bus.
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_bit,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  cs,
  output logic                  oe,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data
);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wval_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic [2:0]            bit_q;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] rmw_val;
  logic                  accept;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rsp_q;
  assign accept    = req_valid && req_ready;

  assign oe      = (state_q == S_RD);
  assign we      = (state_q == S_WR);
  assign cs      = oe || we;
  assign address = addr_q;
  assign data    = we ? wval_q : {DATA_WIDTH{1'bz}};

  // Modify the value as it arrives on the bus, so
  // the write value is ready for the WR cycle.
  assign mask    = DATA_WIDTH'(1) << bit_q;
  assign rmw_val = (op_q == OP_SETBIT) ?
                   (data | mask) : (data & ~mask);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = (req_op == OP_WRITE) ? S_WR : S_RD;
      S_RD:
        state_d = (op_q == OP_READ) ? S_RSP : S_WR;
      S_WR:
        state_d = S_RSP;
      S_RSP:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wval_q  <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_e'(req_op);
        addr_q <= req_addr;
        wval_q <= req_wdata;
        bit_q  <= req_bit;
      end
      if (state_q == S_RD) begin
        rdata_q <= data;
        if (op_q != OP_READ)
          wval_q <= rmw_val;
      end
      if (state_d == S_RSP) begin
        if (state_q == S_RD)
          rsp_q <= data;
        else if (op_q == OP_WRITE)
          rsp_q <= wval_q;
        else
          rsp_q <= rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed vectors, reset
// abort, and random back-to-back ops vs a model.
module tb_io_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic [2:0] req_bit;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       cs, oe, we;
  logic [5:0] address;
  wire  [7:0] data;

  logic [7:0] mem [64];
  logic [7:0] model_mem [64];
  int n_checks = 0;
  int n_fail = 0;
  bit done = 0;

  always #5 clk = ~clk;

  io_bus_master #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bit(req_bit),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs(cs), .oe(oe), .we(we),
    .address(address), .data(data)
  );

  // Responder: drives reads, samples writes on the falling edge.
  assign data = (cs && oe && !we) ? mem[address] : 8'bz;

  always @(negedge clk)
    if (cs && we) mem[address] = data;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && !done) begin
      check("oe_we_excl", 32'(oe && we), 0);
      if (oe) check("rd_bus", 32'(data), 32'(mem[address]));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [2:0] bitn;
    logic [7:0] exp_rdata;
    int         exp_lat;
    logic [7:0] exp_reg;
    int         exp_rd;
    int         exp_wr;
    logic [7:0] exp_bus;
  } vec_t;

  task automatic do_op(input logic [1:0] op,
                       input logic [5:0] a,
                       input logic [7:0] wd,
                       input logic [2:0] b,
                       output logic [7:0] rd,
                       output int lat,
                       output int nrd,
                       output int nwr,
                       output logic [7:0] wbus);
    check("ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_op = op; req_addr = a;
    req_wdata = wd; req_bit = b;
    tick();
    req_valid = 0;
    req_op = 2'($urandom); req_addr = 6'($urandom);
    req_wdata = 8'($urandom); req_bit = 3'($urandom);
    lat = -1; nrd = 0; nwr = 0; wbus = '0; rd = '0;
    for (int k = 0; k < 8; k++) begin
      check("ready_busy", 32'(req_ready), 0);
      if (rsp_valid) begin
        lat = k + 1;
        rd = rsp_rdata;
        break;
      end
      check("addr", 32'(address), 32'(a));
      if (cs && oe) nrd++;
      if (cs && we) begin nwr++; wbus = data; end
      tick();
    end
    check("rsp_timeout", 32'(lat > 0), 1);
    tick();
    check("rsp_pulse", 32'(rsp_valid), 0);
    check("rsp_hold", 32'(rsp_rdata), 32'(rd));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] exp;
    int         acc;
  } pend_t;

  initial begin
    vec_t vecs [8];
    pend_t q [$];
    logic [7:0] rd, wbus;
    int lat, nrd, nwr, cyc;

    vecs[0] = '{0, 6'h05, 8'h00, 0, 8'hA5, 2, 8'hA5, 1, 0, 8'h00};
    vecs[1] = '{1, 6'h10, 8'h3C, 0, 8'h3C, 2, 8'h3C, 0, 1, 8'h3C};
    vecs[2] = '{0, 6'h10, 8'h00, 0, 8'h3C, 2, 8'h3C, 1, 0, 8'h00};
    vecs[3] = '{2, 6'h02, 8'h00, 4, 8'h81, 3, 8'h91, 1, 1, 8'h91};
    vecs[4] = '{3, 6'h02, 8'h00, 0, 8'h91, 3, 8'h90, 1, 1, 8'h90};
    vecs[5] = '{2, 6'h02, 8'h00, 7, 8'h90, 3, 8'h90, 1, 1, 8'h90};
    vecs[6] = '{1, 6'h3F, 8'hFF, 0, 8'hFF, 2, 8'hFF, 0, 1, 8'hFF};
    vecs[7] = '{3, 6'h3F, 8'h00, 7, 8'hFF, 3, 8'h7F, 1, 1, 8'h7F};

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[5] = 8'hA5;
    mem[2] = 8'h81;
    reset = 1; req_valid = 0; req_op = 0;
    req_addr = 0; req_wdata = 0; req_bit = 0;

    #2;
    check("rst_cs", 32'(cs), 0);
    check("rst_oe", 32'(oe), 0);
    check("rst_we", 32'(we), 0);
    check("rst_addr", 32'(address), 0);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_rspv", 32'(rsp_valid), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    tick();
    reset = 0;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata,
            vecs[i].bitn, rd, lat, nrd, nwr, wbus);
      check($sformatf("v%0d_rdata", i), 32'(rd),
            32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_lat", i), 32'(lat),
            32'(vecs[i].exp_lat));
      check($sformatf("v%0d_nrd", i), 32'(nrd),
            32'(vecs[i].exp_rd));
      check($sformatf("v%0d_nwr", i), 32'(nwr),
            32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0)
        check($sformatf("v%0d_bus", i), 32'(wbus),
              32'(vecs[i].exp_bus));
      check($sformatf("v%0d_reg", i),
            32'(mem[vecs[i].addr]), 32'(vecs[i].exp_reg));
    end

    // Reset during the RD cycle of a SETBIT.
    req_valid = 1; req_op = 2; req_addr = 6'h02; req_bit = 1;
    tick();
    req_valid = 0;
    check("abort_in_rd", 32'(cs && oe), 1);
    #2 reset = 1;
    #1;
    check("abort_cs", 32'(cs), 0);
    check("abort_oe", 32'(oe), 0);
    check("abort_we", 32'(we), 0);
    check("abort_addr", 32'(address), 0);
    check("abort_ready", 32'(req_ready), 1);
    check("abort_rspv", 32'(rsp_valid), 0);
    check("abort_rdata", 32'(rsp_rdata), 0);
    tick();
    tick();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      check("abort_norsp", 32'(rsp_valid), 0);
      check("abort_nowr", 32'(we), 0);
      tick();
    end
    check("abort_reg", 32'(mem[2]), 32'h90);
    do_op(0, 6'h02, 0, 0, rd, lat, nrd, nwr, wbus);
    check("post_rst_rd", 32'(rd), 32'h90);
    check("post_rst_lat", 32'(lat), 2);

    // Random back-to-back ops with req_valid held high.
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      model_mem[i] = mem[i];
    end
    cyc = 0;
    req_valid = 1;
    for (int c = 0; c < 400; c++) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("rnd_spurious_rsp", 1, 0);
        end else begin
          pend_t p;
          p = q.pop_front();
          check("rnd_rdata", 32'(rsp_rdata), 32'(p.exp));
          check("rnd_lat", 32'(cyc + 1 - p.acc),
                (p.op == 0 || p.op == 1) ? 2 : 3);
        end
      end
      req_op = 2'($urandom); req_addr = 6'($urandom);
      req_wdata = 8'($urandom); req_bit = 3'($urandom);
      if (req_ready) begin
        pend_t p;
        logic [7:0] old;
        check("rnd_one_outst", 32'(q.size()), 0);
        old = model_mem[req_addr];
        p.op = req_op;
        p.acc = cyc + 1;
        case (req_op)
          2'd0: p.exp = old;
          2'd1: begin
            p.exp = req_wdata;
            model_mem[req_addr] = req_wdata;
          end
          2'd2: begin
            p.exp = old;
            model_mem[req_addr] = old | 8'(1 << req_bit);
          end
          default: begin
            p.exp = old;
            model_mem[req_addr] = old & ~8'(1 << req_bit);
          end
        endcase
        q.push_back(p);
      end
      tick();
      cyc++;
    end
    req_valid = 0;
    for (int c = 0; c < 6 && q.size() > 0; c++) begin
      if (rsp_valid) begin
        pend_t p;
        p = q.pop_front();
        check("rnd_rdata", 32'(rsp_rdata), 32'(p.exp));
      end
      tick();
    end
    check("rnd_drained", 32'(q.size()), 0);
    for (int i = 0; i < 64; i++)
      check($sformatf("rnd_mem%0d", i),
            32'(mem[i]), 32'(model_mem[i]));

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 The block SHALL have parameters DATA_WIDTH, default 8, I/O data width; and ADDR_WIDTH, default 6, I/O register address width.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit, asynchronous active-high reset.
REQ-004 Port req_valid SHALL be an input, 1 bit, meaning the requester presents an operation.
REQ-005 Port req_ready SHALL be an output, 1 bit, meaning the block accepts a request this cycle.
REQ-006 Port req_op SHALL be an input, 2 bits, the operation: READ=0, WRITE=1, SETBIT=2, CLRBIT=3.
REQ-007 Port req_addr SHALL be an input, ADDR_WIDTH bits, the target I/O register.
REQ-008 Port req_wdata SHALL be an input, DATA_WIDTH bits, the write data for WRITE.
REQ-009 Port req_bit SHALL be an input, 3 bits, the bit index for SETBIT and CLRBIT.
REQ-010 Port rsp_valid SHALL be an output, 1 bit, a single-cycle completion pulse.
REQ-011 Port rsp_rdata SHALL be an output, DATA_WIDTH bits: read data for READ, the pre-modify value for SETBIT/CLRBIT, req_wdata for WRITE.
REQ-012 Ports cs, oe and we SHALL be outputs, 1 bit each: chip select, output enable and write enable to the I/O register file.
REQ-013 Port address SHALL be an output, ADDR_WIDTH bits, the bus address.
REQ-014 Port data SHALL be an inout, DATA_WIDTH bits, the shared bidirectional bus, driven only during write cycles.

Function
REQ-015 The FSM SHALL have the states IDLE, RD, WR and RSP; req_ready SHALL be 1 only in IDLE.
REQ-016 The request SHALL be accepted on a rising edge with req_valid && req_ready; op, addr, wdata and bit are registered, and later input changes are ignored.
REQ-017 On acceptance the FSM SHALL go IDLE->WR for WRITE, and IDLE->RD for READ, SETBIT and CLRBIT.
REQ-018 In RD the outputs SHALL be cs=1, oe=1, we=0, address=registered addr and data=hi-Z; the data bus is captured into rdata_q at the rising edge that ends RD.
REQ-019 The FSM SHALL go RD->RSP for READ, and RD->WR for SETBIT/CLRBIT with write value rdata_q | (1<<bit) or rdata_q & ~(1<<bit) respectively.
REQ-020 In WR the outputs SHALL be cs=1, we=1, oe=0, address=registered addr, with data driven with the write value for the whole cycle; the responder samples on the falling edge.
REQ-021 The FSM SHALL go WR->RSP; in RSP, rsp_valid=1 for exactly one cycle with rsp_rdata valid; RSP->IDLE.
REQ-022 Latency from the acceptance edge to the rsp_valid edge SHALL be 2 cycles for READ and WRITE, and 3 for SETBIT/CLRBIT; throughput is one outstanding operation.
REQ-023 Outside RD and WR the outputs SHALL be cs=0, oe=0, we=0 and data=hi-Z; oe and we are never both 1.
REQ-024 rsp_rdata SHALL hold its value until the next RSP.
REQ-025 Writes to read-only registers SHALL be issued normally; the block does not filter addresses.
REQ-026 A bit index is 3 bits; if DATA_WIDTH > 8, only bits 0..7 SHALL be addressable.

Reset
REQ-027 Asserting reset in any state SHALL immediately force state=IDLE, cs=0, oe=0, we=0, data=hi-Z, address=0, req_ready=1, rsp_valid=0 and rsp_rdata=0.
REQ-028 An operation interrupted by reset SHALL be abandoned with no response; an RMW aborted in RD SHALL produce no write.
REQ-029 The first request after reset deassertion SHALL be acceptable on the first rising edge.

Structure
REQ-030 The op encodings (READ, WRITE, SETBIT, CLRBIT) and the FSM state encodings SHALL reside in the shared defines header.
REQ-031 The block SHALL be a single module with no sub-module; the tristate driver and mask logic are inline.

Verification
REQ-032 Scenario: responder reg 0x05=0xA5, READ addr 0x05 -> one RD cycle with cs=1, oe=1; rsp_valid 2 cycles after acceptance; rsp_rdata=0xA5.
REQ-033 Scenario: WRITE addr 0x10 data 0x3C -> one WR cycle with data bus=0x3C; readback gives 0x3C; rsp_rdata=0x3C.
REQ-034 Scenario: reg 0x02=0x81, SETBIT bit 4 -> RD then WR with data=0x91; rsp_rdata=0x81 at 3 cycles; reg=0x91. Then CLRBIT bit 0 -> reg=0x90.
REQ-035 Scenario: req_valid held high with back-to-back ops -> req_ready=0 during RD, WR and RSP; no second acceptance before IDLE; every op gets exactly one rsp_valid.
REQ-036 Scenario: reset asserted mid-SETBIT during RD -> bus inactive and data hi-Z with no clock edge; register unchanged; no rsp_valid.
REQ-037 Scenario (all tests): assertion that data is never driven while oe=1, and that oe && we never occurs.
